// File: rtl/vq_pkg.sv
// Shared constants and FSM encoding for the VQ compressor stream scheduler.
package vq_pkg;

  localparam int CODEWORDS = 64;
  localparam int CB_IDX_W  = 6;
  localparam int ADDR_W    = 18;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_CB = 3'd1,
    ST_STREAM  = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/vq_valid_pipe.sv
// Fixed-latency {valid, address} shift register that tracks pixels from the
// image RAM read to the tag RAM write.
module vq_valid_pipe #(
  parameter int LAT = 2,
  parameter int AW  = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          first_valid,
  output logic          last_valid,
  output logic [AW-1:0] last_addr
);

  logic [LAT-1:0] valid_q;
  logic [AW-1:0]  addr_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: address stages are cleared too, so the tag address reads 0 straight after reset.
      for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign first_valid = valid_q[0];
  assign last_valid  = valid_q[LAT-1];
  assign last_addr   = addr_q[LAT-1];

endmodule

// File: rtl/vq_stream_scheduler.sv
// Sequencer: loads 64 codewords, streams every pixel at one per cycle, then
// drains the fixed-latency pipeline before signalling done.
module vq_stream_scheduler #(
  parameter int PIXELS   = 65536,
  parameter int PIPE_LAT = 2,
  parameter int ADDR_W   = vq_pkg::ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        RAM_W_OE,
  output logic [ADDR_W-1:0]           RAM_W_A,
  output logic                        cb_we,
  output logic [vq_pkg::CB_IDX_W-1:0] cb_idx,
  output logic                        RAM_IF_OE,
  output logic [ADDR_W-1:0]           RAM_IF_A,
  output logic                        pix_valid,
  output logic                        RAM_TAG_WE,
  output logic [ADDR_W-1:0]           RAM_TAG_A,
  output logic                        busy,
  output logic                        done
);
  import vq_pkg::*;

  state_t              state_q, state_d;
  logic [CB_IDX_W-1:0] load_q, load_d;   // codeword index in LOAD_CB, drain count in DRAIN
  logic [ADDR_W-1:0]   pix_q, pix_d;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      load_q  <= '0;
      pix_q   <= '0;
      cb_we   <= 1'b0;
      cb_idx  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      pix_q   <= pix_d;
      cb_we   <= RAM_W_OE;
      cb_idx  <= RAM_W_A[CB_IDX_W-1:0];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d   = state_q;
    load_d    = load_q;
    pix_d     = pix_q;
    RAM_W_OE  = 1'b0;
    RAM_W_A   = '0;
    RAM_IF_OE = 1'b0;
    RAM_IF_A  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_CB;
          load_d  = '0;
          pix_d   = '0;
        end
      end
      ST_LOAD_CB: begin
        busy     = 1'b1;
        RAM_W_OE = 1'b1;
        RAM_W_A  = {{(ADDR_W-CB_IDX_W){1'b0}}, load_q};
        if (load_q == CB_IDX_W'(CODEWORDS-1)) begin
          state_d = ST_STREAM;
          load_d  = '0;
          pix_d   = '0;
        end else begin
          load_d = load_q + 1'b1;
        end
      end
      ST_STREAM: begin
        busy      = 1'b1;
        RAM_IF_OE = 1'b1;
        RAM_IF_A  = pix_q;
        if (pix_q == ADDR_W'(PIXELS-1)) begin
          state_d = ST_DRAIN;
          load_d  = '0;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (load_q == CB_IDX_W'(PIPE_LAT-1)) state_d = ST_DONE;
        else                                 load_d  = load_q + 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = ST_LOAD_CB;
          load_d  = '0;
          pix_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  vq_valid_pipe #(
    .LAT (PIPE_LAT),
    .AW  (ADDR_W)
  ) u_valid_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (RAM_IF_OE),
    .in_addr     (RAM_IF_A),
    .first_valid (pix_valid),
    .last_valid  (RAM_TAG_WE),
    .last_addr   (RAM_TAG_A)
  );

endmodule

// File: doc/vq_stream_scheduler.md
# vq_stream_scheduler

Top-level sequencer for the 64-codeword vector-quantisation image compressor. Loads the 64 RGB codewords from the weight RAM into the codebook registers, then streams every pixel address of the image RAM through the VEP array and winner-select logic. Writes one tag per pixel into the tag RAM, fully pipelined at one pixel per cycle. Replaces per-pixel handshaking with a fixed-latency valid/address pipeline.

## Interface
- `PIXELS`, 65536: number of pixels in the image, 1..2^18.
- `CODEWORDS`, 64: codebook depth; fixed at 64 (8x8 VEP grid).
- `PIPE_LAT`, 2: cycles from `RAM_IF_A` issue to valid winner (1 RAM read + 1 VEP register), 1..4.
- `ADDR_W`, 18: RAM address width.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a compression run; sampled only in IDLE and DONE.
- `RAM_W_OE`  out  1  weight RAM read enable.
- `RAM_W_A`  out  ADDR_W  weight RAM address, codeword index 0..63.
- `cb_we`  out  1  write `RAM_W_Q` into codebook register `cb_idx`.
- `cb_idx`  out  6  codebook register index.
- `RAM_IF_OE`  out  1  image RAM read enable.
- `RAM_IF_A`  out  ADDR_W  pixel address.
- `pix_valid`  out  1  `RAM_IF_Q` valid at VEP inputs this cycle.
- `RAM_TAG_WE`  out  1  tag RAM write enable (data assembled outside from winner x/y).
- `RAM_TAG_A`  out  ADDR_W  tag address = pixel address.
- `busy`  out  1  high in LOAD_CB, STREAM, DRAIN.
- `done`  out  1  high while in DONE.

## Operation
- States: IDLE, LOAD_CB, STREAM, DRAIN, DONE.
- IDLE: all outputs 0. `start`=1 -> LOAD_CB, load counter cleared.
- LOAD_CB: `RAM_W_OE`=1, `RAM_W_A`=k, k=0..63, one per cycle. Next cycle `cb_we`=1, `cb_idx`=k. After k=63 -> STREAM.
- STREAM: `RAM_IF_OE`=1, `RAM_IF_A`=p, p=0..PIXELS-1, one per cycle; no stalls. After p=PIXELS-1 -> DRAIN.
- Valid pipeline: depth-PIPE_LAT shift of {valid, address}. Stage 1 drives `pix_valid`; final stage drives `RAM_TAG_WE` and `RAM_TAG_A`.
- DRAIN: `RAM_IF_OE`=0; stays exactly PIPE_LAT cycles until pipeline empty -> DONE.
- DONE: `done`=1 held. `start`=1 -> LOAD_CB (full rerun, codebook reloaded); else stay.
- `start` in LOAD_CB/STREAM/DRAIN ignored.
- Counters: load counter 6 bits, terminal 63; pixel counter ADDR_W bits, terminal PIXELS-1. No wrap; terminal compare, not overflow.
- PIXELS=1: STREAM lasts one cycle.

## Timing
- Reset: state IDLE, counters 0, pipeline cleared; every output 0 on the cycle after `rst` sampled high.
- Reset mid-run: abort immediately; no further `cb_we`/`RAM_TAG_WE`; tags already written are not undone.
- `start` sampled high at cycle 0 -> LOAD_CB cycles 1..64; `cb_we` cycles 2..65.
- STREAM cycles 65..64+PIXELS. Codeword 63 written at end of cycle 65, before first `pix_valid` (cycle 66 for PIPE_LAT=2).
- Pixel p: `RAM_IF_A`=p at cycle 65+p; `RAM_TAG_WE`=1 with `RAM_TAG_A`=p at cycle 65+p+PIPE_LAT.
- DONE entered at cycle 65+PIXELS+PIPE_LAT; `busy` falls same cycle.
- Throughput: 1 tag/cycle; run length PIXELS+PIPE_LAT+65 cycles.
- `cb_we` and `RAM_IF_OE` are high together only in cycle 65; no other overlap of W and IF reads.

## Structure
- Package `vq_pkg`: state encoding, CODEWORDS=64, CB_IDX_W=6, ADDR_W=18.
- Sub-module `vq_valid_pipe`: parameterised PIPE_LAT shift register of {valid, ADDR_W address}, synchronous clear on `rst`.
- FSM and counters in top of block; no arithmetic beyond counter increments.

## Test plan
- Reset: assert `rst` 3 cycles -> all outputs 0, `done`=0, `busy`=0.
- Full run PIXELS=16, PIPE_LAT=2, `start` at cycle 0 -> `cb_we` cycles 2..65 with `cb_idx` 0..63; `RAM_TAG_WE` cycles 67..82, `RAM_TAG_A` 0..15; `done` from 83.
- PIXELS=1 -> single `RAM_IF_A`=0 at 65, single tag write at 67, `done` at 68.
- `start` pulsed at cycle 30 and 70 of a run -> ignored, timing identical to plain run; `start` in DONE -> rerun from LOAD_CB, identical trace offset.
- `rst` at cycle 70 (STREAM) -> next cycle all outputs 0, IDLE; later `start` gives clean full run.
- PIPE_LAT=4, PIXELS=8 -> tag for pixel p at cycle 69+p, `done` at 77.
